uart_reg_bank: RTL and testbench

Parametrised second-generation UART configuration/status register bank with read-back. It sits between the cfg bus and the UART TX/RX/CRC datapath. Over the first generation it adds:
- a one-deep TX holding buffer with automatic start handshake
- RX data capture with overrun detection
- sticky W1C status flags
- an interrupt output
- registered read data

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_tx_holding.sv | 90 +++++++++
 rtl/uart_reg_bank.sv | 193 +++++++++++++++++++
 tb/tb_uart_reg_bank.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART configuration/status register bank:
// register word addresses, STATUS bit positions and the TX holding FSM states.
package uart_pkg;

  // Register word addresses
  localparam int unsigned UART_CONFIG  = 0;
  localparam int unsigned UART_CMD     = 1;
  localparam int unsigned UART_TX_DATA = 2;
  localparam int unsigned UART_RX_DATA = 3;
  localparam int unsigned UART_STATUS  = 4;
  localparam int unsigned UART_IRQ_EN  = 5;

  // STATUS / IRQ_EN bit positions
  localparam int ST_TX_FULL    = 0;
  localparam int ST_RX_VALID   = 1;
  localparam int ST_RX_OVERRUN = 2;
  localparam int ST_CRC_ERR    = 3;
  localparam int ST_TX_DROP    = 4;

  // TX holding buffer states
  typedef enum logic [1:0] {
    TX_IDLE   = 2'd0,  // buffer empty
    TX_LOADED = 2'd1,  // buffer full, no start requested yet
    TX_ARMED  = 2'd2,  // buffer full, waiting for transmitter ready and tx_en
    TX_START  = 2'd3   // start pulse cycle, buffer already empty again
  } tx_state_t;

endpackage

// File: rtl/uart_tx_holding.sv
// One-deep TX holding buffer with a start request handshake towards the
// transmitter. A start request may arrive before the character; it is then
// remembered and the buffer goes straight to ARMED when loaded.
module uart_tx_holding
  import uart_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              i_wr,          // TX_DATA register write
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_start_req,   // CMD[0] write
  input  logic              i_tx_en,
  input  logic              i_tx_ready,
  output logic              o_tx_start,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_tx_full,
  output logic              o_tx_drop      // write hit a full buffer this cycle
);

  tx_state_t         r_state;
  tx_state_t         w_state_next;
  logic              r_pre_armed;
  logic              w_pre_armed_next;
  logic [DATA_W-1:0] r_buf;
  logic [DATA_W-1:0] w_buf_next;
  logic              w_fire;
  logic              r_tx_start;
  logic [DATA_W-1:0] r_tx_data;

  assign o_tx_full  = (r_state == TX_LOADED) || (r_state == TX_ARMED);
  assign o_tx_drop  = i_wr && o_tx_full;
  assign o_tx_start = r_tx_start;
  assign o_tx_data  = r_tx_data;

  // Next-state logic: START behaves like IDLE since the buffer has been handed off
  always_comb begin
    w_state_next     = r_state;
    w_pre_armed_next = r_pre_armed;
    w_buf_next       = r_buf;
    w_fire           = 1'b0;
    case (r_state)
      TX_IDLE, TX_START: begin
        if (i_wr) begin
          w_buf_next       = i_wr_data;
          w_state_next     = (r_pre_armed || i_start_req) ? TX_ARMED : TX_LOADED;
          w_pre_armed_next = 1'b0;
        end else begin
          w_state_next = TX_IDLE;
          if (i_start_req) begin
            w_pre_armed_next = 1'b1;
          end
        end
      end
      TX_LOADED: begin
        if (i_start_req) begin
          w_state_next = TX_ARMED;
        end
      end
      TX_ARMED: begin
        if (i_tx_ready && i_tx_en) begin
          w_fire       = 1'b1;
          w_state_next = TX_START;
        end
      end
      default: w_state_next = TX_IDLE;
    endcase
  end

  // State, buffer and registered start pulse / character
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_state     <= TX_IDLE;
      r_pre_armed <= 1'b0;
      r_buf       <= '0;
      r_tx_start  <= 1'b0;
      r_tx_data   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_pre_armed <= w_pre_armed_next;
      r_buf       <= w_buf_next;
      r_tx_start  <= w_fire;
      if (w_fire) begin
        r_tx_data <= r_buf;
      end
    end
  end

endmodule

// File: rtl/uart_reg_bank.sv
// UART configuration/status register bank: CONFIG/CMD/TX_DATA/RX_DATA/
// STATUS/IRQ_EN registers, RX capture with overrun, sticky W1C flags,
// registered read data and a registered level interrupt.
module uart_reg_bank
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              cfg_cs,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr_i,
  input  logic [31:0]       cfg_data_i,
  output logic [31:0]       cfg_data_o,
  output logic              cfg_rvalid_o,
  output logic              tx_en_o,
  output logic              rx_en_o,
  output logic              crc_en_o,
  output logic [DIV_W-1:0]  clock_divider_o,
  output logic              tx_start_o,
  output logic [DATA_W-1:0] tx_data_o,
  input  logic              tx_ready_i,
  input  logic              rx_valid_i,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic              crc_err_i,
  output logic              irq_o
);

  logic              r_crc_en;
  logic              r_tx_en;
  logic              r_rx_en;
  logic [DIV_W-1:0]  r_div;
  logic [4:0]        r_irq_en;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic [31:0]       r_rdata;
  logic              r_rvalid;
  logic              r_irq;

  logic              w_wr;
  logic              w_rd;
  logic              w_sel_cfg;
  logic              w_sel_cmd;
  logic              w_sel_txd;
  logic              w_sel_rxd;
  logic              w_sel_st;
  logic              w_sel_ien;
  logic              w_rx_cap;
  logic              w_rx_pop;
  logic              w_rx_flush;
  logic              w_tx_full;
  logic              w_tx_drop;
  logic              w_st_wr;
  logic [ST_TX_DROP:ST_RX_OVERRUN] w_sticky_set;
  logic [ST_TX_DROP:ST_RX_OVERRUN] w_sticky;
  logic [4:0]        w_status;
  logic [31:0]       w_rd_mux;
  logic              w_unused_data;

  // Not every write-data bit maps to a register field for all parameter sets
  assign w_unused_data = ^cfg_data_i;

  assign w_wr      = cfg_cs && cfg_we;
  assign w_rd      = cfg_cs && !cfg_we;
  assign w_sel_cfg = (cfg_addr_i == ADDR_W'(UART_CONFIG));
  assign w_sel_cmd = (cfg_addr_i == ADDR_W'(UART_CMD));
  assign w_sel_txd = (cfg_addr_i == ADDR_W'(UART_TX_DATA));
  assign w_sel_rxd = (cfg_addr_i == ADDR_W'(UART_RX_DATA));
  assign w_sel_st  = (cfg_addr_i == ADDR_W'(UART_STATUS));
  assign w_sel_ien = (cfg_addr_i == ADDR_W'(UART_IRQ_EN));

  assign w_rx_cap   = rx_valid_i && r_rx_en;
  assign w_rx_pop   = w_rd && w_sel_rxd;
  assign w_rx_flush = w_wr && w_sel_cmd && cfg_data_i[1];
  assign w_st_wr    = w_wr && w_sel_st;

  uart_tx_holding #(
    .DATA_W (DATA_W)
  ) u_tx_holding (
    .clk         (clk),
    .rst_i       (rst_i),
    .i_wr        (w_wr && w_sel_txd),
    .i_wr_data   (cfg_data_i[DATA_W-1:0]),
    .i_start_req (w_wr && w_sel_cmd && cfg_data_i[0]),
    .i_tx_en     (r_tx_en),
    .i_tx_ready  (tx_ready_i),
    .o_tx_start  (tx_start_o),
    .o_tx_data   (tx_data_o),
    .o_tx_full   (w_tx_full),
    .o_tx_drop   (w_tx_drop)
  );

  // Overrun only when an unread character is actually lost (no pop/flush this cycle)
  assign w_sticky_set[ST_RX_OVERRUN] = w_rx_cap && r_rx_valid && !w_rx_pop && !w_rx_flush;
  assign w_sticky_set[ST_CRC_ERR]    = crc_err_i && r_crc_en;
  assign w_sticky_set[ST_TX_DROP]    = w_tx_drop;

  genvar gi;
  generate
    for (gi = ST_RX_OVERRUN; gi <= ST_TX_DROP; gi++) begin : g_sticky
      logic r_flag;
      // Sticky flag: W1C clear, a same-cycle set event wins
      always_ff @(posedge clk) begin
        if (rst_i) begin
          r_flag <= 1'b0;
        end else begin
          r_flag <= (r_flag && !(w_st_wr && cfg_data_i[gi])) || w_sticky_set[gi];
        end
      end
      assign w_sticky[gi] = r_flag;
    end
  endgenerate

  assign w_status = {w_sticky, r_rx_valid, w_tx_full};

  // CONFIG and IRQ_EN register writes
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_crc_en <= 1'b0;
      r_tx_en  <= 1'b0;
      r_rx_en  <= 1'b0;
      r_div    <= '0;
      r_irq_en <= '0;
    end else begin
      if (w_wr && w_sel_cfg) begin
        r_crc_en <= cfg_data_i[0];
        r_tx_en  <= cfg_data_i[1];
        r_rx_en  <= cfg_data_i[2];
        r_div    <= cfg_data_i[16 +: DIV_W];
      end
      if (w_wr && w_sel_ien) begin
        r_irq_en <= cfg_data_i[4:0];
      end
    end
  end

  // RX holding register: capture beats pop and flush in the same cycle
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else if (w_rx_cap) begin
      r_rx_data  <= rx_data_i;
      r_rx_valid <= 1'b1;
    end else if (w_rx_pop || w_rx_flush) begin
      r_rx_valid <= 1'b0;
    end
  end

  // Read multiplexer; write-only and unmapped addresses read as zero
  always_comb begin
    w_rd_mux = '0;
    if (w_sel_cfg) begin
      w_rd_mux[0]          = r_crc_en;
      w_rd_mux[1]          = r_tx_en;
      w_rd_mux[2]          = r_rx_en;
      w_rd_mux[16 +: DIV_W] = r_div;
    end else if (w_sel_rxd) begin
      w_rd_mux[DATA_W-1:0] = r_rx_data;
    end else if (w_sel_st) begin
      w_rd_mux[4:0] = w_status;
    end else if (w_sel_ien) begin
      w_rd_mux[4:0] = r_irq_en;
    end
  end

  // Registered read data (held between reads), read strobe and interrupt
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_rvalid <= w_rd;
      if (w_rd) begin
        r_rdata <= w_rd_mux;
      end
      r_irq <= |(w_status & r_irq_en);
    end
  end

  assign cfg_data_o      = r_rdata;
  assign cfg_rvalid_o    = r_rvalid;
  assign tx_en_o         = r_tx_en;
  assign rx_en_o         = r_rx_en;
  assign crc_en_o        = r_crc_en;
  assign clock_divider_o = r_div;
  assign irq_o           = r_irq;

endmodule

// File: tb/tb_uart_reg_bank.sv
// Bench for uart_reg_bank: directed steps followed by random traffic, every
// cycle compared against a transaction-level model of the register bank.
module tb_uart_reg_bank;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        cfg_cs = 1'b0;
  logic        cfg_we = 1'b0;
  logic [4:0]  cfg_addr_i = '0;
  logic [31:0] cfg_data_i = '0;
  logic [31:0] cfg_data_o;
  logic        cfg_rvalid_o;
  logic        tx_en_o, rx_en_o, crc_en_o;
  logic [15:0] clock_divider_o;
  logic        tx_start_o;
  logic [7:0]  tx_data_o;
  logic        tx_ready_i = 1'b0;
  logic        rx_valid_i = 1'b0;
  logic [7:0]  rx_data_i = '0;
  logic        crc_err_i = 1'b0;
  logic        irq_o;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_reg_bank #(.DATA_W(8), .DIV_W(16), .ADDR_W(5)) dut (
    .clk             (clk),
    .rst_i           (rst_i),
    .cfg_cs          (cfg_cs),
    .cfg_we          (cfg_we),
    .cfg_addr_i      (cfg_addr_i),
    .cfg_data_i      (cfg_data_i),
    .cfg_data_o      (cfg_data_o),
    .cfg_rvalid_o    (cfg_rvalid_o),
    .tx_en_o         (tx_en_o),
    .rx_en_o         (rx_en_o),
    .crc_en_o        (crc_en_o),
    .clock_divider_o (clock_divider_o),
    .tx_start_o      (tx_start_o),
    .tx_data_o       (tx_data_o),
    .tx_ready_i      (tx_ready_i),
    .rx_valid_i      (rx_valid_i),
    .rx_data_i       (rx_data_i),
    .crc_err_i       (crc_err_i),
    .irq_o           (irq_o)
  );

  // Reference model state (register-level view of the block)
  bit        m_crc_en, m_tx_en, m_rx_en;
  bit [15:0] m_div;
  bit [4:0]  m_irq_en;
  bit [7:0]  m_buf;
  bit        m_full, m_armed;
  bit [7:0]  m_rxd;
  bit        m_rxv, m_ovr, m_crce, m_drop;
  bit        m_start;
  bit [7:0]  m_txd;
  bit [31:0] m_rdata;
  bit        m_rvalid, m_irq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, compare all outputs
  task automatic step(input logic cs, input logic we, input logic [4:0] addr,
                      input logic [31:0] wd, input logic rdy, input logic rxvi,
                      input logic [7:0] rxdi, input logic crci, input logic rst);
    bit        wr, rd, fire, cap, pop, flush, txw, cmd0;
    bit [4:0]  st;
    bit [31:0] rv;
    rst_i = rst; cfg_cs = cs; cfg_we = we; cfg_addr_i = addr; cfg_data_i = wd;
    tx_ready_i = rdy; rx_valid_i = rxvi; rx_data_i = rxdi; crc_err_i = crci;

    wr = cs && we;
    rd = cs && !we;
    st = {m_drop, m_crce, m_ovr, m_rxv, m_full};
    case (addr)
      5'd0:    rv = {m_div, 13'd0, m_rx_en, m_tx_en, m_crc_en};
      5'd3:    rv = {24'd0, m_rxd};
      5'd4:    rv = {27'd0, st};
      5'd5:    rv = {27'd0, m_irq_en};
      default: rv = 32'd0;
    endcase

    if (rst) begin
      m_crc_en = 0; m_tx_en = 0; m_rx_en = 0; m_div = 0; m_irq_en = 0;
      m_buf = 0; m_full = 0; m_armed = 0; m_rxd = 0; m_rxv = 0;
      m_ovr = 0; m_crce = 0; m_drop = 0; m_start = 0; m_txd = 0;
      m_rdata = 0; m_rvalid = 0; m_irq = 0;
    end else begin
      m_irq = |(st & m_irq_en);
      m_rvalid = rd;
      if (rd) m_rdata = rv;
      // Transmit side: start request, one-deep buffer
      txw  = wr && addr == 5'd2;
      cmd0 = wr && addr == 5'd1 && wd[0];
      fire = m_armed && m_full && rdy && m_tx_en;
      m_start = fire;
      if (fire) m_txd = m_buf;
      if (wr && addr == 5'd4) begin
        if (wd[2]) m_ovr = 0;
        if (wd[3]) m_crce = 0;
        if (wd[4]) m_drop = 0;
      end
      if (txw && m_full) m_drop = 1;
      m_armed = fire ? 1'b0 : (m_armed || cmd0);
      if (txw && !m_full) begin
        m_buf = wd[7:0];
        m_full = 1;
      end else if (fire) begin
        m_full = 0;
      end
      // Receive side
      cap   = rxvi && m_rx_en;
      pop   = rd && addr == 5'd3;
      flush = wr && addr == 5'd1 && wd[1];
      if (cap && m_rxv && !pop && !flush) m_ovr = 1;
      if (cap) begin
        m_rxd = rxdi;
        m_rxv = 1;
      end else if (pop || flush) begin
        m_rxv = 0;
      end
      if (crci && m_crc_en) m_crce = 1;
      if (wr && addr == 5'd0) begin
        m_crc_en = wd[0]; m_tx_en = wd[1]; m_rx_en = wd[2]; m_div = wd[31:16];
      end
      if (wr && addr == 5'd5) m_irq_en = wd[4:0];
    end

    @(posedge clk);
    #1;
    check("rvalid", 32'(cfg_rvalid_o), 32'(m_rvalid));
    check("rdata", cfg_data_o, m_rdata);
    check("tx_start", 32'(tx_start_o), 32'(m_start));
    check("tx_data", 32'(tx_data_o), 32'(m_txd));
    check("irq", 32'(irq_o), 32'(m_irq));
    check("enables", 32'({crc_en_o, tx_en_o, rx_en_o}), 32'({m_crc_en, m_tx_en, m_rx_en}));
    check("divider", 32'(clock_divider_o), 32'(m_div));
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [31:0] d, input logic rdy);
    step(1, 1, a, d, rdy, 0, 8'h00, 0, 0);
  endtask

  task automatic rd_reg(input logic [4:0] a, input logic rdy);
    step(1, 0, a, 32'h0, rdy, 0, 8'h00, 0, 0);
  endtask

  task automatic idle(input logic rdy);
    step(0, 0, 5'd0, 32'h0, rdy, 0, 8'h00, 0, 0);
  endtask

  int start_cnt;

  initial begin
    // 1. Reset, read every register
    step(0, 0, 5'd0, 32'h0, 0, 0, 8'h00, 0, 1);
    step(0, 0, 5'd0, 32'h0, 0, 0, 8'h00, 0, 1);
    for (int a = 0; a < 6; a++) begin
      rd_reg(5'(a), 0);
      check("reset_read_val", cfg_data_o, 32'h0);
      check("reset_read_valid", 32'(cfg_rvalid_o), 32'h1);
    end
    idle(0);
    check("rvalid_one_cycle", 32'(cfg_rvalid_o), 32'h0);

    // 2. CONFIG write and read-back
    wr_reg(5'd0, 32'h0208_0007, 0);
    rd_reg(5'd0, 0);
    check("config_readback", cfg_data_o, 32'h0208_0007);
    check("config_divider", 32'(clock_divider_o), 32'h0208);

    // 3. TX: load, arm, wait for ready, one start pulse, then drop on full
    wr_reg(5'd2, 32'h0000_00A5, 0);
    wr_reg(5'd1, 32'h0000_0001, 0);
    for (int i = 0; i < 10; i++) idle(0);
    start_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      start_cnt += int'(tx_start_o);
    end
    check("tx_start_count", 32'(start_cnt), 32'd1);
    check("tx_data_a5", 32'(tx_data_o), 32'hA5);
    rd_reg(5'd4, 0);
    check("tx_full_cleared", 32'(cfg_data_o[0]), 32'h0);
    wr_reg(5'd2, 32'h0000_005A, 0);
    wr_reg(5'd2, 32'h0000_0077, 0);
    rd_reg(5'd4, 0);
    check("tx_drop_set", cfg_data_o & 32'h11, 32'h11);

    // 4. RX overrun and W1C
    step(0, 0, 5'd0, 32'h0, 0, 1, 8'h11, 0, 0);
    step(0, 0, 5'd0, 32'h0, 0, 1, 8'h22, 0, 0);
    rd_reg(5'd4, 0);
    check("rx_overrun_set", cfg_data_o & 32'h06, 32'h06);
    rd_reg(5'd3, 0);
    check("rx_data_22", cfg_data_o, 32'h22);
    wr_reg(5'd4, 32'h0000_0004, 0);
    rd_reg(5'd4, 0);
    check("rx_overrun_cleared", cfg_data_o & 32'h06, 32'h00);

    // 5. Interrupt on CRC error, W1C racing a new error
    wr_reg(5'd5, 32'h0000_0008, 0);
    step(0, 0, 5'd0, 32'h0, 0, 0, 8'h00, 1, 0);
    idle(0);
    check("irq_crc", 32'(irq_o), 32'h1);
    step(1, 1, 5'd4, 32'h0000_0008, 0, 0, 8'h00, 1, 0);
    rd_reg(5'd4, 0);
    check("crc_w1c_race", cfg_data_o & 32'h08, 32'h08);

    // 6. Reset while ARMED with RX data pending
    wr_reg(5'd1, 32'h0000_0001, 0);
    step(0, 0, 5'd0, 32'h0, 0, 1, 8'h33, 0, 0);
    step(0, 0, 5'd0, 32'h0, 0, 0, 8'h00, 0, 1);
    check("rst_irq", 32'(irq_o), 32'h0);
    check("rst_cfg_data", cfg_data_o, 32'h0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check("no_start_after_rst", 32'(tx_start_o), 32'h0);
    end

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] a;
      logic [31:0] d;
      a = ($urandom_range(0, 15) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
      d = $urandom;
      if (a == 5'd1 && $urandom_range(0, 3) != 0) d[1] = 1'b0;
      if (a == 5'd0 && $urandom_range(0, 3) != 0) d[2:0] = 3'b111;
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d,
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
           8'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 299) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
